// File: rtl/restoring_array_divider_if.sv
// Operand/result bundle for the 8-by-4 restoring array divider.
// master drives operands and borrow-ins; slave (the divider) returns q, r, ovf.
interface restoring_array_divider_if;
  logic [7:0] x;
  logic [3:0] y;
  logic       bin1;
  logic       bin2;
  logic       bin3;
  logic       bin4;
  logic [3:0] q;
  logic [3:0] r;
  logic       ovf;

  modport master (
    output x, y, bin1, bin2, bin3, bin4,
    input  q, r, ovf
  );

  modport slave (
    input  x, y, bin1, bin2, bin3, bin4,
    output q, r, ovf
  );
endinterface

// File: rtl/restoring_array_divider.sv
// Unsigned 8-by-4 restoring array divider with registered q, r and ovf.
// Define RESTORING_DIV_PIPE_IN_EN to add an input register stage (latency 2 instead of 1).
module restoring_array_divider (
  input  logic                        clk,
  input  logic                        rst,
  restoring_array_divider_if.slave    bus
);

  logic [7:0] x_a;
  logic [3:0] y_a;
  logic [3:0] bin_a;  // bin_a[i] feeds the row producing q[i]; bin1 drives q[3]

`ifdef RESTORING_DIV_PIPE_IN_EN
  logic [7:0] x_in_q, x_in_d;
  logic [3:0] y_in_q, y_in_d;
  logic [3:0] bin_in_q, bin_in_d;

  always_comb begin
    x_in_d   = bus.x;
    y_in_d   = bus.y;
    bin_in_d = {bus.bin1, bus.bin2, bus.bin3, bus.bin4};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_in_q   <= '0;
      y_in_q   <= '0;
      bin_in_q <= '0;
    end else begin
      x_in_q   <= x_in_d;
      y_in_q   <= y_in_d;
      bin_in_q <= bin_in_d;
    end
  end

  assign x_a   = x_in_q;
  assign y_a   = y_in_q;
  assign bin_a = bin_in_q;
`else
  assign x_a   = bus.x;
  assign y_a   = bus.y;
  assign bin_a = {bus.bin1, bus.bin2, bus.bin3, bus.bin4};
`endif

  logic [3:0] q_q, q_d;
  logic [3:0] r_q, r_d;
  logic       ovf_q, ovf_d;
  logic [3:0] p_row;
  logic [4:0] t_row;
  logic [5:0] d_row;

  // One subtract/restore row per quotient bit, MSB first; d_row[5] is the row borrow-out.
  always_comb begin
    q_d   = '0;
    p_row = x_a[7:4];
    t_row = '0;
    d_row = '0;
    for (int i = 3; i >= 0; i--) begin
      t_row = {p_row, x_a[i]};
      d_row = {1'b0, t_row} - {2'b00, y_a} - {5'b00000, bin_a[i]};
      if (!d_row[5]) begin
        q_d[i] = 1'b1;
        p_row  = d_row[3:0];
      end else begin
        p_row  = t_row[3:0];
      end
    end
    r_d   = p_row;
    ovf_d = (y_a == 4'h0) | (x_a[7:4] >= y_a);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      r_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      r_q   <= r_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.q   = q_q;
  assign bus.r   = r_q;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_restoring_array_divider.sv
// Scoreboard bench for restoring_array_divider: driver pushes model results, monitor pops/compares.
// Honours RESTORING_DIV_PIPE_IN_EN for the expected latency.
module tb_restoring_array_divider;

`ifdef RESTORING_DIV_PIPE_IN_EN
  localparam int unsigned Lat = 2;
`else
  localparam int unsigned Lat = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  restoring_array_divider_if bus ();

  restoring_array_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int unsigned edge_no;
    logic [3:0]  q;
    logic [3:0]  r;
    logic        ovf;
    logic        prop;
    logic [7:0]  x;
    logic [3:0]  y;
  } exp_t;

  exp_t        sb[$];
  int unsigned edge_cnt = 0;
  int          checks   = 0;
  int          failures = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Long division, one bit at a time; row k owns quotient bit 4-k and borrow-in b[k].
  function automatic exp_t model(input logic [7:0] x, input logic [3:0] y, input logic [4:1] b);
    exp_t e;
    int   p;
    int   qv;
    p  = int'(x) / 16;
    qv = 0;
    for (int k = 1; k <= 4; k++) begin
      int i;
      int t;
      int need;
      i    = 4 - k;
      t    = p * 2 + int'(x[i]);
      need = int'(y) + int'(b[k]);
      if (t >= need) begin
        qv = qv + (1 << i);
        p  = (t - need) % 16;
      end else begin
        p  = t % 16;
      end
    end
    e.edge_no = 0;
    e.q       = 4'(qv);
    e.r       = 4'(p);
    e.ovf     = (y == 4'h0) || ((int'(x) / 16) >= int'(y));
    e.prop    = (b == 4'b0000) && !e.ovf;
    e.x       = x;
    e.y       = y;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req,
                     input int unsigned e);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%0h required=%0h", nm, e, act, req);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].edge_no == edge_cnt) begin
      exp_t e;
      e = sb.pop_front();
      chk("q", 32'(bus.q), 32'(e.q), e.edge_no);
      chk("r", 32'(bus.r), 32'(e.r), e.edge_no);
      chk("ovf", 32'(bus.ovf), 32'(e.ovf), e.edge_no);
      if (e.prop) begin
        chk("identity", 32'(int'(bus.q) * int'(e.y) + int'(bus.r)), 32'(e.x), e.edge_no);
        chk("r_lt_y", 32'(bus.r < e.y), 32'd1, e.edge_no);
      end
    end
  end

  task automatic drive(input bit r_i, input logic [7:0] x, input logic [3:0] y,
                       input logic [4:1] b);
    exp_t e;
    @(negedge clk);
    rst      = r_i;
    bus.x    = x;
    bus.y    = y;
    bus.bin1 = b[1];
    bus.bin2 = b[2];
    bus.bin3 = b[3];
    bus.bin4 = b[4];
    if (r_i) begin
      // Reset zeroes the result due this edge, superseding anything already in flight.
      e         = model(8'h00, 4'h1, 4'b0000);
      e.q       = '0;
      e.r       = '0;
      e.ovf     = 1'b0;
      e.prop    = 1'b0;
      e.edge_no = edge_cnt + 1;
      if (sb.size() > 0 && sb[$].edge_no == edge_cnt + 1) sb[$] = e;
      else sb.push_back(e);
      if (Lat == 2) begin
        // The flushed input stage presents all-zero operands on the following edge.
        e         = model(8'h00, 4'h0, 4'b0000);
        e.edge_no = edge_cnt + 2;
        sb.push_back(e);
      end
    end else begin
      e         = model(x, y, b);
      e.edge_no = edge_cnt + Lat;
      sb.push_back(e);
    end
  endtask

  initial begin
    bus.x    = '0;
    bus.y    = '0;
    bus.bin1 = 1'b0;
    bus.bin2 = 1'b0;
    bus.bin3 = 1'b0;
    bus.bin4 = 1'b0;

    drive(1'b1, 8'hFF, 4'h1, 4'b0000);
    drive(1'b1, 8'hFF, 4'h1, 4'b0000);
    drive(1'b0, 8'hFF, 4'h1, 4'b0000);

    drive(1'b0, 8'd9,   4'd2,  4'b0000);
    drive(1'b0, 8'd10,  4'd2,  4'b0000);
    drive(1'b0, 8'd12,  4'd3,  4'b0000);
    drive(1'b0, 8'd20,  4'd3,  4'b0000);
    drive(1'b0, 8'd45,  4'd0,  4'b0000);
    drive(1'b0, 8'd240, 4'd15, 4'b0000);
    drive(1'b0, 8'd239, 4'd15, 4'b0000);
    drive(1'b0, 8'd0,   4'd1,  4'b0000);
    drive(1'b0, 8'd9,   4'd2,  4'b0001);
    drive(1'b0, 8'd13,  4'd1,  4'b1010);

    for (int xi = 0; xi < 256; xi++) begin
      for (int yi = 1; yi < 16; yi++) begin
        drive(1'b0, 8'(xi), 4'(yi), 4'b0000);
      end
    end

    drive(1'b0, 8'd100, 4'd7,  4'b0000);
    drive(1'b1, 8'd55,  4'd3,  4'b0000);
    drive(1'b0, 8'd77,  4'd5,  4'b0000);
    drive(1'b0, 8'd200, 4'd13, 4'b0000);

    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 31) == 0), 8'($urandom), 4'($urandom), 4'($urandom));
    end
    drive(1'b0, 8'd0, 4'd1, 4'b0000);

    repeat (Lat + 2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
